// File: rtl/regfile_2w2r_sb.sv
// Two-write / two-read register file with a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_2w2r_sb #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int R0_ZERO = 1,
   localparam int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              rv1,
   output logic              rv2,
   input  logic              we3,
   input  logic [ADDR_W-1:0] wa3,
   input  logic [DATA_W-1:0] wd3,
   input  logic              we4,
   input  logic [ADDR_W-1:0] wa4,
   input  logic [DATA_W-1:0] wd4,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_a,
   output logic [DEPTH-1:0]  busy
);

   localparam bit R0_HARD = (R0_ZERO != 0);

   logic [DATA_W-1:0] regs [DEPTH];
   logic [ADDR_W-1:0] ra   [2];
   logic [DATA_W-1:0] rd   [2];
   logic              rv   [2];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
         localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
         if (R0_HARD && gi == 0) begin : g_zero
            assign regs[gi] = '0;
            assign busy[gi] = 1'b0;
         end else begin : g_live
            logic [DATA_W-1:0] data_reg;
            logic              busy_reg;

            // Port 4 beats port 3 on an address clash; a new reservation beats a return.
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) begin
                  data_reg <= '0;
                  busy_reg <= 1'b0;
               end else begin
                  if (we4 && wa4 == IDX)
                     data_reg <= wd4;
                  else if (we3 && wa3 == IDX)
                     data_reg <= wd3;
                  if (rsv_en && rsv_a == IDX)
                     busy_reg <= 1'b1;
                  else if (we4 && wa4 == IDX)
                     busy_reg <= 1'b0;
               end
            end

            assign regs[gi] = data_reg;
            assign busy[gi] = busy_reg;
         end
      end
   endgenerate

   assign ra[0] = ra1;
   assign ra[1] = ra2;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rd
         logic is_r0;
         assign is_r0 = R0_HARD && (ra[gi] == '0);

         always_comb begin
            rd[gi] = regs[ra[gi]];
            rv[gi] = ~busy[ra[gi]];
`ifdef REGFILE_BYPASS_EN
            // A returning write also clears the pending flag, so the operand is valid now.
            if (!is_r0) begin
               if (we4 && wa4 == ra[gi]) begin
                  rd[gi] = wd4;
                  rv[gi] = 1'b1;
               end else if (we3 && wa3 == ra[gi]) begin
                  rd[gi] = wd3;
               end
            end
`endif
         end
      end
   endgenerate

   assign rd1 = rd[0];
   assign rd2 = rd[1];
   assign rv1 = rv[0];
   assign rv2 = rv[1];

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Directed self-checking bench for regfile_2w2r_sb (default parameters).
module tb_regfile_2w2r_sb;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [ADDR_W-1:0] ra1, ra2, wa3, wa4, rsv_a;
   logic [DATA_W-1:0] rd1, rd2, wd3, wd4;
   logic              rv1, rv2, we3, we4, rsv_en;
   logic [DEPTH-1:0]  busy;

   int checks = 0;
   int errors = 0;

   regfile_2w2r_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .R0_ZERO(1)) dut (
      .clk(clk), .reset_n(reset_n),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .rv1(rv1), .rv2(rv2),
      .we3(we3), .wa3(wa3), .wd3(wd3),
      .we4(we4), .wa4(wa4), .wd4(wd4),
      .rsv_en(rsv_en), .rsv_a(rsv_a), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic idle();
      we3 = 1'b0; wa3 = '0; wd3 = '0;
      we4 = 1'b0; wa4 = '0; wd4 = '0;
      rsv_en = 1'b0; rsv_a = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      ra1 = 5'd1; ra2 = 5'd1;
      idle();
      #2;
      checks++;
      if (rd1 !== 32'h0 || rv1 !== 1'b1 || busy !== 32'h0) begin
         errors++;
         $display("FAIL reset_state rd1=%h rv1=%b busy=%h want 0/1/0", rd1, rv1, busy);
      end
      tick(); reset_n = 1'b1;
      tick();
      we3 = 1'b1; wa3 = 5'd1; wd3 = 32'd6;
      rsv_en = 1'b1; rsv_a = 5'd1;
      tick(); idle();
      #1;
      checks++;
      if (rd1 !== 32'd6 || rv1 !== 1'b0) begin
         errors++;
         $display("FAIL pre_reset_write rd1=%h rv1=%b want 6/0", rd1, rv1);
      end
      // Asynchronous reset mid-cycle.
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (rd1 !== 32'h0 || rv1 !== 1'b1 || busy !== 32'h0) begin
         errors++;
         $display("FAIL async_reset rd1=%h rv1=%b busy=%h want 0/1/0", rd1, rv1, busy);
      end
      tick(); #2 reset_n = 1'b1;
      tick();
      we3 = 1'b1; wa3 = 5'd1; wd3 = 32'd6;
      tick(); idle();
      #1;
      checks++;
      if (rd1 !== 32'd6 || rv1 !== 1'b1) begin
         errors++;
         $display("FAIL reset_write rd1=%h rv1=%b want 6/1", rd1, rv1);
      end
      $display("test_reset done");
   endtask

   task automatic test_r0();
      we3 = 1'b1; wa3 = 5'd0; wd3 = 32'd8;
      rsv_en = 1'b1; rsv_a = 5'd0;
      tick(); idle();
      we4 = 1'b1; wa4 = 5'd0; wd4 = 32'hDEAD;
      tick(); idle();
      ra1 = 5'd0; ra2 = 5'd0;
      #1;
      checks++;
      if (rd1 !== 32'h0 || rv1 !== 1'b1 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL r0_port1 rd1=%h rv1=%b busy0=%b want 0/1/0", rd1, rv1, busy[0]);
      end
      checks++;
      if (rd2 !== 32'h0 || rv2 !== 1'b1) begin
         errors++;
         $display("FAIL r0_port2 rd2=%h rv2=%b want 0/1", rd2, rv2);
      end
      $display("test_r0 done");
   endtask

   task automatic test_conflict();
      we3 = 1'b1; wa3 = 5'd5; wd3 = 32'd7;
      we4 = 1'b1; wa4 = 5'd5; wd4 = 32'd9;
      tick(); idle();
      ra1 = 5'd5; ra2 = 5'd5;
      #1;
      checks++;
      if (rd1 !== 32'd9 || rd2 !== 32'd9 || rv1 !== 1'b1) begin
         errors++;
         $display("FAIL conflict rd1=%h rd2=%h rv1=%b want 9/9/1", rd1, rd2, rv1);
      end
      $display("test_conflict done");
   endtask

   task automatic test_scoreboard();
      ra2 = 5'd3;
      rsv_en = 1'b1; rsv_a = 5'd3;
      tick(); idle();
      #1;
      checks++;
      if (busy !== 32'h0000_0008 || rv2 !== 1'b0) begin
         errors++;
         $display("FAIL sb_reserve busy=%h rv2=%b want 00000008/0", busy, rv2);
      end
      we3 = 1'b1; wa3 = 5'd3; wd3 = 32'd4;
      tick(); idle();
      #1;
      checks++;
      if (busy !== 32'h0000_0008 || rd2 !== 32'd4 || rv2 !== 1'b0) begin
         errors++;
         $display("FAIL sb_alu_write busy=%h rd2=%h rv2=%b want 00000008/4/0", busy, rd2, rv2);
      end
      rsv_en = 1'b1; rsv_a = 5'd3;
      tick(); idle();
      #1;
      checks++;
      if (busy !== 32'h0000_0008) begin
         errors++;
         $display("FAIL sb_rereserve busy=%h want 00000008", busy);
      end
      we4 = 1'b1; wa4 = 5'd3; wd4 = 32'h1234;
      tick(); idle();
      #1;
      checks++;
      if (busy !== 32'h0 || rd2 !== 32'h1234 || rv2 !== 1'b1) begin
         errors++;
         $display("FAIL sb_return busy=%h rd2=%h rv2=%b want 0/1234/1", busy, rd2, rv2);
      end
      we4 = 1'b1; wa4 = 5'd6; wd4 = 32'h66;
      ra1 = 5'd6;
      tick(); idle();
      #1;
      checks++;
      if (busy !== 32'h0 || rd1 !== 32'h66 || rv1 !== 1'b1) begin
         errors++;
         $display("FAIL sb_return_idle busy=%h rd1=%h rv1=%b want 0/66/1", busy, rd1, rv1);
      end
      $display("test_scoreboard done");
   endtask

   task automatic test_collision();
      ra1 = 5'd4;
      rsv_en = 1'b1; rsv_a = 5'd4;
      tick(); idle();
      #1;
      checks++;
      if (busy[4] !== 1'b1) begin
         errors++;
         $display("FAIL coll_setup busy4=%b want 1", busy[4]);
      end
      rsv_en = 1'b1; rsv_a = 5'd4;
      we4 = 1'b1; wa4 = 5'd4; wd4 = 32'hAA;
      tick(); idle();
      #1;
      checks++;
      if (rd1 !== 32'hAA || busy !== 32'h0000_0010 || rv1 !== 1'b0) begin
         errors++;
         $display("FAIL collision rd1=%h busy=%h rv1=%b want aa/00000010/0", rd1, busy, rv1);
      end
      we4 = 1'b1; wa4 = 5'd4; wd4 = 32'hAA;
      tick(); idle();
      $display("test_collision done");
   endtask

   task automatic test_bypass();
      we3 = 1'b1; wa3 = 5'd2; wd3 = 32'h11;
      tick(); idle();
      ra1 = 5'd2; ra2 = 5'd7;
      we4 = 1'b1; wa4 = 5'd2; wd4 = 32'h55;
      we3 = 1'b1; wa3 = 5'd7; wd3 = 32'h77;
      #1;
`ifdef REGFILE_BYPASS_EN
      checks++;
      if (rd1 !== 32'h55 || rv1 !== 1'b1 || rd2 !== 32'h77) begin
         errors++;
         $display("FAIL bypass_pre rd1=%h rv1=%b rd2=%h want 55/1/77", rd1, rv1, rd2);
      end
`else
      checks++;
      if (rd1 !== 32'h11 || rv1 !== 1'b1 || rd2 !== 32'h0) begin
         errors++;
         $display("FAIL bypass_pre rd1=%h rv1=%b rd2=%h want 11/1/0", rd1, rv1, rd2);
      end
`endif
      tick(); idle();
      #1;
      checks++;
      if (rd1 !== 32'h55 || rd2 !== 32'h77) begin
         errors++;
         $display("FAIL bypass_post rd1=%h rd2=%h want 55/77", rd1, rd2);
      end
      $display("test_bypass done");
   endtask

   initial begin
      test_reset();
      test_r0();
      test_conflict();
      test_scoreboard();
      test_collision();
      test_bypass();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_2w2r_sb.md
Name: regfile_2w2r_sb

Overview:
Parametrised successor to the single-write 3-port register file. It has two combinational read ports and two synchronous write ports. Port 3 carries ALU writeback and port 4 carries long-latency (load/multiply) return. A per-register busy scoreboard lets the pipeline see whether an operand is still pending. The block sits in the decode stage of the datapath.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
R0_ZERO, 1, 1 = register 0 hardwired to zero; 0 = register 0 is an ordinary register

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
ra1  input  ADDR_W  read address, port 1
ra2  input  ADDR_W  read address, port 2
rd1  output  DATA_W  read data, port 1
rd2  output  DATA_W  read data, port 2
rv1  output  1  port 1 operand valid (register not busy)
rv2  output  1  port 2 operand valid
we3  input  1  write enable, ALU port
wa3  input  ADDR_W  write address, ALU port
wd3  input  DATA_W  write data, ALU port
we4  input  1  write enable, long-latency return port
wa4  input  ADDR_W  write address, return port
wd4  input  DATA_W  write data, return port
rsv_en  input  1  reserve request: mark register as pending
rsv_a  input  ADDR_W  register to reserve
busy  output  DEPTH  scoreboard vector, bit i = register i pending

Behaviour:
- Reset: reset_n low asynchronously clears all registers to 0 and busy to all-0.
  - This forces rd1=rd2=0 and rv1=rv2=1 immediately, including mid-operation.
  - The first write is accepted on the first rising edge after reset_n rises.
- Reads are combinational with zero latency: rdN = reg[raN], rvN = ~busy[raN].
- Writes take effect at the rising edge. The new value is visible on rdN after that edge (1-cycle write-to-read latency).
- Write conflict: we3 and we4 both asserted with wa3==wa4 -> wd4 is written, wd3 is dropped.
- Scoreboard, evaluated per rising edge:
  - rsv_en sets busy[rsv_a].
  - we4 clears busy[wa4].
  - we3 does NOT change busy.
- Simultaneous rsv_en and we4 to the same address: busy ends set (the new reservation wins); the register still takes wd4.
- rsv_en on an already-busy register: it stays busy; no error is flagged.
- we4 to a non-busy register: the write happens and busy stays 0.
- R0_ZERO=1:
  - Writes to address 0 are ignored on both ports.
  - rsv_a=0 is ignored.
  - rdN=0 and rvN=1 when raN=0.
  - busy[0] is always 0.
- R0_ZERO=0: register 0 behaves like any other register.
- Both read ports may address the same register; there are no read-port restrictions.
- Implementation: register array plus a DEPTH-bit busy vector, no FSM. Address decoding has full DEPTH coverage; there are no out-of-range addresses.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: same-cycle write-to-read forwarding.
  - If we4 && wa4==raN (and not R0 under R0_ZERO): rdN=wd4 and rvN=1.
  - Else if we3 && wa3==raN: rdN=wd3, and rvN reflects busy unchanged.
  - Port 4 has priority over port 3.
  - State update timing is identical to the non-bypass build.
- Undefined: no forwarding. Reads return the pre-edge value and pre-edge busy; write latency is 1 cycle.

Test Plan:
1. Reset/basic write: assert reset_n=0 mid-run after writing 6 to r1 -> rd1=0 immediately. Release, then we3=1, wa3=1, wd3=6, one edge, ra1=1 -> rd1=6, rv1=1.
2. R0 hardwired (R0_ZERO=1): we3=1, wa3=0, wd3=8; rsv_en=1, rsv_a=0; one edge, ra1=0 -> rd1=0, rv1=1, busy[0]=0.
3. Port conflict: we3=we4=1, wa3=wa4=5, wd3=7, wd4=9; one edge -> rd(5)=9.
4. Scoreboard: rsv_en on r3 -> next cycle busy[3]=1, rv2=0 for ra2=3. Then we3 to r3 with 4 -> busy still 1. Then we4 to r3 with 0x1234 -> busy[3]=0, rd2=0x1234, rv2=1.
5. Reserve/return collision: busy[4]=1; same edge rsv_en with rsv_a=4 and we4 with wa4=4, wd4=0xAA -> rd=0xAA, busy[4]=1.
6. Bypass: with REGFILE_BYPASS_EN, we4 wa4=2 wd4=0x55 and ra1=2 in the same cycle -> rd1=0x55 before the edge. Without the macro -> rd1 holds the old value until after the edge.
